// File: rtl/picture_loader.sv
`default_nettype none
// ============================================================================
// picture_loader -- streams 8-bit palette indices into an image RAM, row-major
// Revision: 1.0
// ============================================================================
module picture_loader #(
  parameter int WIDTH     = 72,
  parameter int HEIGHT    = 512,
  parameter int STRIDE    = 72,
  parameter int ADDR_BITS = 16
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic                 window,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_data,
  output logic                 busy,
  output logic                 done
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0]     LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] STRIDE_A = ADDR_BITS'(STRIDE);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [ADDR_BITS-1:0]   row_base_q, row_base_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]             mem_data_q, mem_data_d;
  logic                   done_q, done_d;
  logic                   xfer;

  assign in_ready = (state_q == LOAD) && window && !abort;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q == LOAD);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign done     = done_q;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = LOAD;
          row_base_d = base_addr;
          col_d      = '0;
          row_d      = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer) begin
          mem_we_d   = 1'b1;
          // row_base tracks the start of the current row, so the address is a
          // running sum and wraps naturally at 2^ADDR_BITS.
          mem_addr_d = row_base_q + ADDR_BITS'(col_q);
          mem_data_d = in_data;
          if (col_q == LAST_COL) begin
            col_d      = '0;
            row_base_d = row_base_q + STRIDE_A;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_picture_loader.sv
`default_nettype none
// ============================================================================
// tb_picture_loader -- randomized scoreboard bench for picture_loader
// Revision: 1.0
// ============================================================================
module tb_picture_loader;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int S  = 8;
  localparam int AB = 16;

  logic          pixel_clk = 1'b0;
  logic          reset;
  logic          start, abort, window, in_valid;
  logic [AB-1:0] base_addr;
  logic [7:0]    in_data;
  logic          in_ready, mem_we, busy, done;
  logic [AB-1:0] mem_addr;
  logic [7:0]    mem_data;

  picture_loader #(.WIDTH(W), .HEIGHT(H), .STRIDE(S), .ADDR_BITS(AB)) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .window    (window),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [AB-1:0] addr;
    logic [7:0]    data;
    logic          dn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a load is just "pixel k of W*H goes to base + row*S + col".
  bit            m_load = 0;
  int            m_k    = 0;
  logic [AB-1:0] m_base = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pixel_clk) begin
    if (!reset) begin
      if (mem_we) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_data", mem_data, e.data);
          chk("done_with_write", done, e.dn);
        end
      end else begin
        chk("done_without_we", done, 0);
      end
    end
  end

  // One clock cycle: drive inputs, check the combinational outputs against the
  // model, record any expected write, then advance past the next rising edge.
  task automatic cyc(input logic s, input logic a, input logic v, input logic w,
                     input logic [7:0] d, input logic [AB-1:0] b);
    logic exp_ready;
    exp_t e;
    start = s; abort = a; in_valid = v; window = w; in_data = d; base_addr = b;
    #1;
    exp_ready = m_load && w && !a;
    chk("in_ready", in_ready, exp_ready);
    chk("busy", busy, m_load);
    if (!m_load) begin
      if (s && !a) begin
        m_load = 1;
        m_k    = 0;
        m_base = b;
      end
    end else if (a) begin
      m_load = 0;
    end else if (exp_ready && v) begin
      e.addr = AB'(int'(m_base) + (m_k / W) * S + (m_k % W));
      e.data = d;
      e.dn   = (m_k == W * H - 1);
      q.push_back(e);
      m_k++;
      if (m_k == W * H) m_load = 0;
    end
    @(posedge pixel_clk);
    #1;
  endtask

  // mode 0: continuous, 1: continuous with abort at pixel abort_at,
  // 2: window gap after 5 pixels, 3: valid 1,0,0 pattern,
  // 4: fully random incl. stray starts, 5: continuous with stray starts.
  task automatic run_load(input int mode, input logic [AB-1:0] b, input int abort_at);
    int   n   = 0;
    int   gap = 0;
    logic s, a, v, w;
    logic [7:0]    d;
    logic [AB-1:0] bb;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, b);
    while (m_load && n < 300) begin
      s = 0; a = 0; v = 1; w = 1; d = 8'(m_k); bb = b;
      case (mode)
        1: a = (m_k == abort_at);
        2: begin
          w = !(m_k >= 5 && gap < 7);
          if (!w) gap++;
        end
        3: v = (n % 3 == 0);
        4: begin
          s  = ($urandom % 8 == 0);
          bb = AB'($urandom);
          v  = ($urandom % 2 == 0);
          w  = ($urandom % 4 != 0);
          d  = 8'($urandom);
        end
        5: begin
          s  = (n % 3 == 0);
          bb = 16'h0500;
        end
        default: ;
      endcase
      cyc(s, a, v, w, d, bb);
      n++;
    end
    if (m_load) begin
      chk("load_timeout_busy", busy, 0);
      m_load = 0;
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 16'h0);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 0; abort = 0; window = 0; in_valid = 0; in_data = '0; base_addr = '0;
    repeat (2) @(posedge pixel_clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge pixel_clk);
    #1;

    run_load(0, 16'h0100, -1);
    run_load(2, 16'h0100, -1);
    run_load(3, 16'h0100, -1);
    run_load(1, 16'h0100, 6);
    run_load(0, 16'h0200, -1);

    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 16'h0400);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 16'h0400);
    chk("start_abort_idle_busy", busy, 0);

    run_load(0, 16'hFFFE, -1);

    // Asynchronous reset between edges in the middle of a row.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0300);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'(m_k), 16'h0300);
    chk("pre_reset_we", mem_we, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_we", mem_we, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    q.delete();
    m_load = 0;
    @(posedge pixel_clk);
    #1 reset = 1'b0;
    repeat (6) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 16'h0300);

    run_load(5, 16'h0300, -1);
    repeat (4) run_load(4, AB'($urandom), -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/picture_loader.md
Name: picture_loader

Overview:
- Writer side of the indexed-colour image memories. The display blobs read these memories through row-major addressing and colour maps.
- Accepts a valid/ready stream of 8-bit palette indices and writes one WIDTH x HEIGHT image into a single-port BRAM write interface, row-major, starting at a programmable base address with a programmable row stride.
- Writes happen only while a gating window is open (normally vblank), so the display never reads a half-updated image. Sits between the host/serial byte source and the image RAM write port.

Parameters:
- WIDTH, 72, image width in pixels (columns per row).
- HEIGHT, 512, image height in rows.
- STRIDE, 72, address increment between rows; STRIDE >= WIDTH; lets a sub-image land inside a wider buffer.
- ADDR_BITS, 16, width of the memory address.

Ports:
- pixel_clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin loading an image; honoured only in IDLE.
- abort  input  1  cancels an in-progress load.
- base_addr  input  ADDR_BITS  address of pixel (0,0); sampled on an accepted start.
- window  input  1  write-permit window (e.g. vblank); transfers occur only while high.
- in_data  input  8  palette index of the next pixel.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_BITS  memory write address.
- mem_data  output  8  memory write data.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle pulse when the final pixel is written.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - busy, done, mem_we are 0; mem_addr, mem_data are 0.
  - col, row and row_base counters are 0.
- States are IDLE and LOAD.
- IDLE -> LOAD on start=1 and abort=0:
  - row_base <= base_addr, col <= 0, row <= 0.
  - busy rises the next cycle.
  - If start and abort are both high in IDLE, abort wins and the state stays IDLE.
- in_ready is combinational: (state==LOAD) && window && !abort. A transfer happens on a cycle where in_valid && in_ready.
- Write latency is one cycle. The cycle after a transfer:
  - mem_we=1.
  - mem_addr = row_base + col, computed modulo 2^ADDR_BITS (it wraps and is not flagged).
  - mem_data = in_data.
  - On any cycle with no transfer in the previous cycle, mem_we=0 and mem_addr/mem_data hold their last values.
- Counter update on each transfer:
  - If col == WIDTH-1: col <= 0, row <= row+1, row_base <= row_base + STRIDE.
  - Otherwise: col <= col+1.
  - Address is built incrementally; no multiplier is used.
- Final pixel (transfer with row==HEIGHT-1 and col==WIDTH-1):
  - State goes to IDLE, so busy=0 the next cycle.
  - done=1 in the same cycle as that pixel's mem_we; done=0 otherwise.
- Window closing mid-image: in_ready drops and the counters freeze. Loading resumes at the same col/row when window reopens. There is no data loss and no duplicate write.
- in_valid low during LOAD: no transfer and no counter change.
- start during LOAD is ignored; base_addr is not resampled.
- abort in LOAD:
  - State goes to IDLE next cycle with no done pulse.
  - in_ready is 0 in the abort cycle, so no transfer occurs.
  - A mem_we from the previous cycle's transfer still completes.
- Reset mid-load clears everything immediately; no further writes are issued.
- Counter widths are clog2(WIDTH) for col and clog2(HEIGHT) for row. Counters never exceed WIDTH-1 / HEIGHT-1.

Test Plan:
1. Basic load, WIDTH=4 HEIGHT=3 STRIDE=8. Setup: base_addr=0x0100, window=1, in_valid always high, data 0..11. Required:
   - 12 writes at 0x100-0x103, 0x108-0x10B, 0x110-0x113, with data matching.
   - done pulses with the write to 0x113; busy is high for exactly 12 cycles.
2. Gating. Same config; drop window after 5 transfers for 7 cycles. Required:
   - in_ready=0 and mem_we=0 throughout the gap (after the 5th write completes).
   - Next write goes to 0x109 with data 5; total of 12 writes with no gaps in addresses.
3. Source stalls. Toggle in_valid 1,0,0,1,... Required: write count equals the number of valid&&ready cycles; addresses are sequential per pattern 1; done only after the 12th pixel.
4. Abort and simultaneous requests:
   - Abort after the 6th transfer: no done; state IDLE; in_ready=0; the 6th write still occurs.
   - A new start with base_addr=0x0200 then writes pixel 0 at 0x200.
   - start+abort together in IDLE: busy stays 0.
5. Address wrap. base_addr=0xFFFE, WIDTH=4, STRIDE=4. Required: first row writes 0xFFFE, 0xFFFF, 0x0000, 0x0001; second row starts at 0x0002.
6. Async reset. Assert reset mid-row, between clock edges. Required:
   - mem_we, busy, done go to 0 immediately.
   - After release, no writes occur until a new start.
   - start during LOAD is ignored (same base, continuous addresses).
